// File: rtl/npc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// npc_ctrl_fsm_if
// Groups the instruction-fetch and load/store handshake signals that the NPC
// control sequencer drives and observes.
//   ifu_req_valid / ifu_req_ready  fetch request handshake
//   ifu_addr                       fetch address
//   ifu_rsp_valid / ifu_rsp_data   fetch response
//   lsu_req_valid / lsu_req_ready  data memory request handshake
//   lsu_rsp_valid                  data memory response (load data / store ack)
// Modports: master = sequencer side, slave = memory/bus side.
// ---------------------------------------------------------------------------
interface npc_ctrl_fsm_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid,
    output ifu_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_data,
    output lsu_req_valid,
    input  lsu_req_ready,
    input  lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_data,
    input  lsu_req_valid,
    output lsu_req_ready,
    output lsu_rsp_valid
  );
endinterface

// File: rtl/npc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// npc_ctrl_fsm
// Multi-cycle control sequencer for the NPC core. Owns the PC, steps the
// combinational decoder/ALU/regfile via a latched instruction and a one-cycle
// write-back strobe, and stops the core on ebreak (halted) or on a fault
// (illegal instruction, misaligned next PC, memory timeout -> error).
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   bus             fetch / load-store handshakes (npc_ctrl_fsm_if.master)
//   inst            latched instruction to decoder/regfile
//   dec_*           decode results of inst (load/store/ebreak/illegal/rd write)
//   exu_next_pc     next PC from datapath
//   pc              architectural PC (also the fetch address)
//   rf_wen          regfile write strobe, only during write-back
//   rf_wdata_sel    0 = ALU result, 1 = load data
//   instret         retired-instruction count
//   halted, error   sticky stop indications
// Parameters:
//   RESET_PC        PC after reset
//   TIMEOUT         max stalled cycles in a request/wait state; 0 disables
// ---------------------------------------------------------------------------
module npc_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  npc_ctrl_fsm_if.master        bus,
  output logic [31:0]           inst,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  dec_is_ebreak,
  input  logic                  dec_illegal,
  input  logic                  dec_rd_wen,
  input  logic [31:0]           exu_next_pc,
  output logic [31:0]           pc,
  output logic                  rf_wen,
  output logic                  rf_wdata_sel,
  output logic [31:0]           instret,
  output logic                  halted,
  output logic                  error
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Watchdog only needs to count up to TIMEOUT-1.
  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);
  localparam logic            WD_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_MEM_REQ    = 3'd3,
    S_MEM_WAIT   = 3'd4,
    S_WB         = 3'd5,
    S_HALT       = 3'd6,
    S_ERR        = 3'd7
  } state_t;

  state_t          state_r;
  logic [31:0]     pc_r;
  logic [31:0]     inst_r;
  logic [31:0]     instret_r;
  logic [WD_W-1:0] wd_r;
  logic            ifu_req_valid_r;
  logic            lsu_req_valid_r;
  logic            wb_r;
  logic            halted_r;
  logic            error_r;

  logic            wait_s;
  logic            hs_s;
  logic            timeout_s;
  logic            aligned_s;

  // Handshake of the current request/wait state and watchdog expiry.
  // A handshake on the last permitted cycle takes precedence over the timeout.
  always_comb begin
    wait_s    = 1'b0;
    hs_s      = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      S_FETCH_REQ: begin
        wait_s = 1'b1;
        hs_s   = bus.ifu_req_ready;
      end
      S_FETCH_WAIT: begin
        wait_s = 1'b1;
        hs_s   = bus.ifu_rsp_valid;
      end
      S_MEM_REQ: begin
        wait_s = 1'b1;
        hs_s   = bus.lsu_req_ready;
      end
      S_MEM_WAIT: begin
        wait_s = 1'b1;
        hs_s   = bus.lsu_rsp_valid;
      end
      default: begin
        wait_s = 1'b0;
        hs_s   = 1'b0;
      end
    endcase
    if (WD_EN && wait_s && !hs_s && (wd_r == WD_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next PC must be word aligned for the instruction to retire.
  always_comb begin
    aligned_s = (exu_next_pc[1:0] == 2'b00);
  end

  // Sequencer: state, PC, instruction latch, retire counter, watchdog and
  // registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= S_FETCH_REQ;
      pc_r            <= RESET_PC;
      inst_r          <= NOP_INST;
      instret_r       <= 32'd0;
      wd_r            <= WD_ZERO;
      ifu_req_valid_r <= 1'b1;
      lsu_req_valid_r <= 1'b0;
      wb_r            <= 1'b0;
      halted_r        <= 1'b0;
      error_r         <= 1'b0;
    end else begin
      // Any state change (handshake or timeout) restarts the watchdog.
      if (wait_s && !hs_s && !timeout_s) begin
        wd_r <= wd_r + WD_ONE;
      end else begin
        wd_r <= WD_ZERO;
      end

      case (state_r)
        S_FETCH_REQ: begin
          if (timeout_s) begin
            state_r         <= S_ERR;
            ifu_req_valid_r <= 1'b0;
            error_r         <= 1'b1;
          end else if (hs_s) begin
            state_r         <= S_FETCH_WAIT;
            ifu_req_valid_r <= 1'b0;
          end else begin
            state_r         <= S_FETCH_REQ;
          end
        end

        S_FETCH_WAIT: begin
          if (timeout_s) begin
            state_r <= S_ERR;
            error_r <= 1'b1;
          end else if (hs_s) begin
            state_r <= S_EXEC;
            inst_r  <= bus.ifu_rsp_data;
          end else begin
            state_r <= S_FETCH_WAIT;
          end
        end

        // Decode results are valid for the freshly latched instruction here.
        S_EXEC: begin
          if (dec_illegal) begin
            state_r  <= S_ERR;
            error_r  <= 1'b1;
          end else if (dec_is_ebreak) begin
            // ebreak retires but leaves the PC pointing at itself.
            state_r   <= S_HALT;
            halted_r  <= 1'b1;
            instret_r <= instret_r + 32'd1;
          end else if (dec_is_load || dec_is_store) begin
            state_r         <= S_MEM_REQ;
            lsu_req_valid_r <= 1'b1;
          end else begin
            state_r <= S_WB;
            wb_r    <= 1'b1;
          end
        end

        S_MEM_REQ: begin
          if (timeout_s) begin
            state_r         <= S_ERR;
            lsu_req_valid_r <= 1'b0;
            error_r         <= 1'b1;
          end else if (hs_s) begin
            state_r         <= S_MEM_WAIT;
            lsu_req_valid_r <= 1'b0;
          end else begin
            state_r         <= S_MEM_REQ;
          end
        end

        S_MEM_WAIT: begin
          if (timeout_s) begin
            state_r <= S_ERR;
            error_r <= 1'b1;
          end else if (hs_s) begin
            state_r <= S_WB;
            wb_r    <= 1'b1;
          end else begin
            state_r <= S_MEM_WAIT;
          end
        end

        // A misaligned target faults without retiring or moving the PC.
        S_WB: begin
          wb_r <= 1'b0;
          if (!aligned_s) begin
            state_r <= S_ERR;
            error_r <= 1'b1;
          end else begin
            state_r         <= S_FETCH_REQ;
            pc_r            <= exu_next_pc;
            instret_r       <= instret_r + 32'd1;
            ifu_req_valid_r <= 1'b1;
          end
        end

        S_HALT: begin
          state_r <= S_HALT;
        end

        S_ERR: begin
          state_r <= S_ERR;
        end

        // Unreachable encoding: fail safe into the fault state.
        default: begin
          state_r         <= S_ERR;
          ifu_req_valid_r <= 1'b0;
          lsu_req_valid_r <= 1'b0;
          wb_r            <= 1'b0;
          error_r         <= 1'b1;
        end
      endcase
    end
  end

  // Write-back strobes follow the live decode; the write is dropped when the
  // next PC faults or the instruction is a store.
  always_comb begin
    rf_wen       = wb_r & dec_rd_wen & ~dec_is_store & aligned_s;
    rf_wdata_sel = wb_r & dec_is_load;
  end

  assign bus.ifu_req_valid = ifu_req_valid_r;
  assign bus.ifu_addr      = pc_r;
  assign bus.lsu_req_valid = lsu_req_valid_r;
  assign inst              = inst_r;
  assign pc                = pc_r;
  assign instret           = instret_r;
  assign halted            = halted_r;
  assign error             = error_r;

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_npc_ctrl_fsm
// Self-checking bench for npc_ctrl_fsm: directed instruction table, a
// mid-operation reset sequence and randomized instructions checked against
// an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_npc_ctrl_fsm;
  localparam int          TO     = 8;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3, K_ILL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal, dec_rd_wen;
  logic [31:0] exu_next_pc, pc, instret;
  logic        rf_wen, rf_wdata_sel, halted, error;

  npc_ctrl_fsm_if bus();

  npc_ctrl_fsm #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
    .dec_rd_wen(dec_rd_wen), .exu_next_pc(exu_next_pc), .pc(pc),
    .rf_wen(rf_wen), .rf_wdata_sel(rf_wdata_sel), .instret(instret),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // One instruction: stimulus + expected/observed outcome.
  typedef struct {
    int          kind;
    logic [31:0] npc;
    logic        rd_wen;
    int          s1, s2, s3, s4;   // stall cycles: fetch req, fetch rsp, mem req, mem rsp
    logic        rst_before;
    int          cyc, wen, sel, lreq;
    logic [31:0] pc_e, ret_e;
    logic        halt_e, err_e;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc, m_ret;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0; bus.ifu_rsp_data = 32'd0;
    bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0;
    dec_illegal = 1'b0; dec_rd_wen = 1'b0; exu_next_pc = 32'd0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    idle_inputs();
    repeat (n) @(negedge clk);
    rst = 1'b1;
    m_pc = RST_PC; m_ret = 32'd0;
    chk("rst.pc", pc, RST_PC);
    chk("rst.ifu_req_valid", 32'(bus.ifu_req_valid), 32'd1);
    chk("rst.ifu_addr", bus.ifu_addr, RST_PC);
    chk("rst.instret", instret, 32'd0);
    chk("rst.inst", inst, 32'h0000_0013);
    chk("rst.quiet", {28'd0, bus.lsu_req_valid, rf_wen, rf_wdata_sel, halted | error}, 32'd0);
  endtask

  // Instruction-level model: walk the phases, each costing stall+1 cycles
  // or TO cycles when it times out.
  function automatic vec_t model(input vec_t v, input logic [31:0] cpc, input logic [31:0] cret);
    vec_t r;
    int   st[4];
    r = v;
    r.cyc = 0; r.wen = 0; r.sel = 0; r.lreq = 0;
    r.pc_e = cpc; r.ret_e = cret; r.halt_e = 1'b0; r.err_e = 1'b0;
    st[0] = v.s1; st[1] = v.s2; st[2] = v.s3; st[3] = v.s4;
    for (int p = 0; p < 2; p++) begin
      if (st[p] >= TO) begin r.cyc += TO; r.err_e = 1'b1; return r; end
      r.cyc += st[p] + 1;
    end
    r.cyc += 1;
    if (v.kind == K_ILL) begin r.err_e = 1'b1; return r; end
    if (v.kind == K_EBRK) begin r.halt_e = 1'b1; r.ret_e = cret + 32'd1; return r; end
    if (v.kind == K_LD || v.kind == K_ST) begin
      r.lreq = (st[2] >= TO) ? TO : st[2] + 1;
      for (int p = 2; p < 4; p++) begin
        if (st[p] >= TO) begin r.cyc += TO; r.err_e = 1'b1; return r; end
        r.cyc += st[p] + 1;
      end
    end
    r.cyc += 1;
    r.sel = (v.kind == K_LD) ? 1 : 0;
    if (v.npc[1:0] != 2'b00) begin r.err_e = 1'b1; return r; end
    r.wen = (v.rd_wen && v.kind != K_ST) ? 1 : 0;
    r.pc_e = v.npc; r.ret_e = cret + 32'd1;
    return r;
  endfunction

  // Acts as fetch/data memory with the requested stalls, starting at a
  // negedge where a fetch request is pending, and records what it sees.
  task automatic run_instr(input string n, input vec_t v, output vec_t o);
    int f_st = 0, w_st = 0, m_st = 0, n_st = 0, addr_bad = 0, inst_bad = 0;
    bit f_acc = 0, f_rsp = 0, m_acc = 0, m_rsp = 0, chk_inst = 0;
    logic [31:0] data;
    o = v; o.cyc = 0; o.wen = 0; o.sel = 0; o.lreq = 0;
    data = $urandom;
    dec_is_load   = (v.kind == K_LD) || ((v.kind >= K_EBRK) && ($urandom_range(0, 1) == 1));
    dec_is_store  = (v.kind == K_ST);
    dec_is_ebreak = (v.kind == K_EBRK) || ((v.kind == K_ILL) && ($urandom_range(0, 1) == 1));
    dec_illegal   = (v.kind == K_ILL);
    dec_rd_wen    = v.rd_wen;
    exu_next_pc   = v.npc;
    while (o.cyc < 300) begin
      if (o.cyc > 0 && ((f_rsp && bus.ifu_req_valid) || halted || error)) break;
      if (rf_wen) o.wen++;
      if (rf_wdata_sel) o.sel++;
      if (bus.lsu_req_valid) o.lreq++;
      if (bus.ifu_req_valid && bus.ifu_addr !== pc) addr_bad++;
      if (chk_inst && inst !== data) inst_bad++;
      bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b0; bus.ifu_rsp_data = $urandom;
      bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
      if (bus.ifu_req_valid && !f_acc) begin
        if (f_st < v.s1) f_st++;
        else begin bus.ifu_req_ready = 1'b1; f_acc = 1; end
      end else if (f_acc && !f_rsp) begin
        if (w_st < v.s2) w_st++;
        else begin bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_data = data; f_rsp = 1; end
      end
      if (bus.lsu_req_valid && !m_acc) begin
        if (m_st < v.s3) m_st++;
        else begin bus.lsu_req_ready = 1'b1; m_acc = 1; end
      end else if (m_acc && !m_rsp) begin
        if (n_st < v.s4) n_st++;
        else begin bus.lsu_rsp_valid = 1'b1; m_rsp = 1; end
      end
      chk_inst = f_rsp;
      @(negedge clk);
      o.cyc++;
    end
    o.pc_e = pc; o.ret_e = instret; o.halt_e = halted; o.err_e = error;
    chk({n, ".ifu_addr"}, addr_bad, 32'd0);
    chk({n, ".inst_latch"}, inst_bad, 32'd0);
  endtask

  task automatic compare(input string n, input vec_t o, input vec_t e);
    chk({n, ".cycles"}, o.cyc, e.cyc);
    chk({n, ".rf_wen_cycles"}, o.wen, e.wen);
    chk({n, ".wdata_sel_cycles"}, o.sel, e.sel);
    chk({n, ".lsu_valid_cycles"}, o.lreq, e.lreq);
    chk({n, ".pc"}, o.pc_e, e.pc_e);
    chk({n, ".instret"}, o.ret_e, e.ret_e);
    chk({n, ".halted"}, 32'(o.halt_e), 32'(e.halt_e));
    chk({n, ".error"}, 32'(o.err_e), 32'(e.err_e));
  endtask

  // Once stopped, nothing may be requested or change, whatever the bus does.
  task automatic sticky_check(input string n);
    logic [31:0] pc0, ret0;
    logic        h0, e0;
    int          bad;
    pc0 = pc; ret0 = instret; h0 = halted; e0 = error; bad = 0;
    bus.ifu_req_ready = 1'b1; bus.ifu_rsp_valid = 1'b1;
    bus.lsu_req_ready = 1'b1; bus.lsu_rsp_valid = 1'b1;
    dec_rd_wen = 1'b1; dec_is_store = 1'b0; exu_next_pc = pc0 + 32'd4;
    repeat (5) begin
      @(negedge clk);
      if (bus.ifu_req_valid || bus.lsu_req_valid || rf_wen || pc !== pc0 ||
          instret !== ret0 || halted !== h0 || error !== e0) bad++;
    end
    chk({n, ".sticky"}, bad, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[12];
    vec_t o, e, v;
    int   r;
    //            kind    npc            rd   s1 s2 s3 s4 rst  cyc wen sel lreq pc             ret     h     e
    tbl[0]  = '{K_ALU,  32'h8000_0004, 1'b1, 0, 0, 0, 0, 1'b1, 4,  1,  0,  0, 32'h8000_0004, 32'd1, 1'b0, 1'b0};
    tbl[1]  = '{K_LD,   32'h8000_0008, 1'b1, 0, 0, 3, 1, 1'b0, 10, 1,  1,  4, 32'h8000_0008, 32'd2, 1'b0, 1'b0};
    tbl[2]  = '{K_ST,   32'h8000_000C, 1'b1, 1, 2, 0, 0, 1'b0, 9,  0,  0,  1, 32'h8000_000C, 32'd3, 1'b0, 1'b0};
    tbl[3]  = '{K_ALU,  32'h8000_0010, 1'b1, 7, 0, 0, 0, 1'b0, 11, 1,  0,  0, 32'h8000_0010, 32'd4, 1'b0, 1'b0};
    tbl[4]  = '{K_EBRK, 32'h8000_1000, 1'b1, 0, 0, 0, 0, 1'b0, 3,  0,  0,  0, 32'h8000_0010, 32'd5, 1'b1, 1'b0};
    tbl[5]  = '{K_ILL,  32'h8000_0004, 1'b1, 0, 0, 0, 0, 1'b1, 3,  0,  0,  0, 32'h8000_0000, 32'd0, 1'b0, 1'b1};
    tbl[6]  = '{K_ALU,  32'h8000_0004, 1'b1, 0, 8, 0, 0, 1'b1, 9,  0,  0,  0, 32'h8000_0000, 32'd0, 1'b0, 1'b1};
    tbl[7]  = '{K_ALU,  32'h8000_0006, 1'b1, 0, 0, 0, 0, 1'b1, 4,  0,  0,  0, 32'h8000_0000, 32'd0, 1'b0, 1'b1};
    tbl[8]  = '{K_LD,   32'h8000_0004, 1'b0, 0, 0, 0, 7, 1'b1, 13, 0,  1,  1, 32'h8000_0004, 32'd1, 1'b0, 1'b0};
    tbl[9]  = '{K_ALU,  32'h8000_0100, 1'b0, 0, 3, 0, 0, 1'b0, 7,  0,  0,  0, 32'h8000_0100, 32'd2, 1'b0, 1'b0};
    tbl[10] = '{K_ST,   32'h8000_0104, 1'b0, 0, 0, 8, 0, 1'b0, 11, 0,  0,  8, 32'h8000_0100, 32'd2, 1'b0, 1'b1};
    tbl[11] = '{K_LD,   32'h8000_0002, 1'b1, 0, 0, 0, 0, 1'b1, 6,  0,  1,  1, 32'h8000_0000, 32'd0, 1'b0, 1'b1};

    rst = 1'b0;
    idle_inputs();
    do_reset(3);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) do_reset(2);
      run_instr($sformatf("vec%0d", i), tbl[i], o);
      compare($sformatf("vec%0d", i), o, tbl[i]);
      if (tbl[i].halt_e || tbl[i].err_e) sticky_check($sformatf("vec%0d", i));
    end

    // Reset while a load request is outstanding.
    do_reset(2);
    dec_is_load = 1'b1; dec_rd_wen = 1'b1; exu_next_pc = 32'h8000_0004;
    bus.ifu_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_req_ready = 1'b0; bus.ifu_rsp_valid = 1'b1; bus.ifu_rsp_data = 32'h0000_a083;
    @(negedge clk);
    bus.ifu_rsp_valid = 1'b0;
    @(negedge clk);
    chk("midrst.lsu_req_valid", 32'(bus.lsu_req_valid), 32'd1);
    chk("midrst.inst", inst, 32'h0000_a083);
    do_reset(1);

    // Randomized instructions against the model.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      v.kind = (r < 7) ? K_ALU : (r < 12) ? K_LD : (r < 16) ? K_ST :
               (r == 16) ? K_EBRK : (r == 17) ? K_ILL : K_ALU;
      v.rd_wen = ($urandom_range(0, 3) != 0);
      v.npc = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4 : {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      if ($urandom_range(0, 15) == 0) v.npc[1:0] = 2'($urandom_range(1, 3));
      v.s1 = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 2);
      v.s2 = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 2);
      v.s3 = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 2);
      v.s4 = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 2);
      v.rst_before = 1'b0;
      e = model(v, m_pc, m_ret);
      run_instr($sformatf("rnd%0d", i), v, o);
      compare($sformatf("rnd%0d", i), o, e);
      m_pc = e.pc_e; m_ret = e.ret_e;
      if (e.halt_e || e.err_e) begin
        sticky_check($sformatf("rnd%0d", i));
        do_reset(1 + $urandom_range(0, 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
